// File: rtl/dmem_ctrl.sv
// dmem_ctrl: word-organised data memory behind valid/ready request and response channels,
// with byte-lane stores, WAIT_STATES wait cycles and misalignment errors. Option: DMEM_PERF_CNT_EN.
module dmem_ctrl #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 12,
  parameter int WAIT_STATES = 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err
`ifdef DMEM_PERF_CNT_EN
  ,
  output logic [31:0]         rd_count,
  output logic [31:0]         wr_count,
  output logic [31:0]         err_count
`endif
);

  localparam int NB    = DATA_W / 8;
  localparam int OB    = $clog2(NB);
  localparam int DEPTH = 2 ** (ADDR_W - OB);
  localparam logic [3:0] LAST_WAIT = 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t state, state_nxt;
  logic [3:0] wait_cnt, wait_cnt_nxt;
  logic accept, commit;

  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [NB-1:0]     lat_be;

  logic                 c_we;
  logic [ADDR_W-1:0]    c_addr;
  logic [DATA_W-1:0]    c_wdata;
  logic [NB-1:0]        c_be;
  logic                 c_misaligned;
  logic [ADDR_W-OB-1:0] c_word;

  logic [DATA_W-1:0] mem [DEPTH];

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    req_ready    = 1'b0;
    accept       = 1'b0;
    commit       = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = !RST;
        accept    = req_valid && !RST;
        if (accept) begin
          if (WAIT_STATES > 0) begin
            state_nxt    = ST_WAIT;
            wait_cnt_nxt = '0;
          end else begin
            state_nxt = ST_RESP;
            commit    = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (wait_cnt == LAST_WAIT) begin
          state_nxt = ST_RESP;
          commit    = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt + 4'd1;
        end
      end
      ST_RESP: begin
        if (resp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // With no wait states the commit happens on the accepting edge, so it must use the live request.
  always_comb begin
    c_we         = lat_we;
    c_addr       = lat_addr;
    c_wdata      = lat_wdata;
    c_be         = lat_be;
    if (state == ST_IDLE) begin
      c_we    = req_we;
      c_addr  = req_addr;
      c_wdata = req_wdata;
      c_be    = req_be;
    end
    c_misaligned = |c_addr[OB-1:0];
    c_word       = c_addr[ADDR_W-1:OB];
  end

  assign resp_valid = (state == ST_RESP);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= ST_IDLE;
      wait_cnt   <= '0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_be     <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (accept) begin
        lat_we    <= req_we;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        lat_be    <= req_be;
      end
      if (commit) begin
        resp_err   <= c_misaligned;
        resp_rdata <= (!c_we && !c_misaligned) ? mem[c_word] : '0;
      end else if (state == ST_RESP && resp_ready) begin
        resp_err   <= 1'b0;
        resp_rdata <= '0;
      end
    end
  end

  // Storage is deliberately left out of reset so committed data survives it.
  always_ff @(posedge CLK) begin
    if (commit && !RST && c_we && !c_misaligned) begin
      for (int i = 0; i < NB; i++) begin
        if (c_be[i]) mem[c_word][8*i +: 8] <= c_wdata[8*i +: 8];
      end
    end
  end

`ifdef DMEM_PERF_CNT_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_count  <= '0;
      wr_count  <= '0;
      err_count <= '0;
    end else if (accept) begin
      if (req_we) wr_count <= wr_count + 32'd1;
      else        rd_count <= rd_count + 32'd1;
      if (|req_addr[OB-1:0]) err_count <= err_count + 32'd1;
    end
  end
`endif

endmodule
